// File: rtl/serial_pkg.sv
// Shared types and constants for the serial shift feeder and its downstream register.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_FRAME_WIDTH = 8;

endpackage

// File: rtl/hold_buffer.sv
// One-entry valid/ready holding register feeding the serialiser.
module hold_buffer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_FRAME_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    logic accept;

    assign in_ready = !hold_full;
    assign accept   = in_valid && !hold_full;

    // A pop on the same edge as an accept leaves the buffer full with the new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end else if (pop) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_shift_feeder.sv
// Serialises buffered parallel words onto serial_in/en with a programmable inter-frame gap.
// Optional even-parity bit per frame when SHIFT_FEEDER_PARITY_EN is defined.
module serial_shift_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_FRAME_WIDTH,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_in,
    output logic             en,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [BW-1:0]    bit_cnt, bit_cnt_next;
    logic [GW-1:0]    gap_cnt, gap_cnt_next;
    logic             frame_done_next;
    logic             load;
    logic             end_frame;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
`ifdef SHIFT_FEEDER_PARITY_EN
    logic             parity, parity_next;
`endif

    hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pop       (load),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
`ifdef SHIFT_FEEDER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            gap_cnt    <= gap_cnt_next;
            frame_done <= frame_done_next;
`ifdef SHIFT_FEEDER_PARITY_EN
            parity     <= parity_next;
`endif
        end
    end

    // Frame completion is resolved once after the case so SHIFT and PARITY share the gap/reload/idle rules.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        gap_cnt_next    = gap_cnt;
        frame_done_next = 1'b0;
        load            = 1'b0;
        end_frame       = 1'b0;
`ifdef SHIFT_FEEDER_PARITY_EN
        parity_next     = parity;
`endif

        case (state)
            IDLE: begin
                if (hold_full) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                if (bit_cnt == LAST_BIT) begin
`ifdef SHIFT_FEEDER_PARITY_EN
                    state_next = PARITY;
`else
                    end_frame  = 1'b1;
`endif
                end else begin
                    bit_cnt_next = bit_cnt + BW'(1);
                end
            end
`ifdef SHIFT_FEEDER_PARITY_EN
            PARITY: begin
                end_frame = 1'b1;
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (end_frame) begin
            frame_done_next = 1'b1;
            if (GAP_CYCLES > 0) begin
                state_next   = GAP;
                gap_cnt_next = '0;
            end else if (hold_full) begin
                load = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        if (load) begin
            state_next   = SHIFT;
            shreg_next   = hold_data;
            bit_cnt_next = '0;
`ifdef SHIFT_FEEDER_PARITY_EN
            parity_next  = ^hold_data;
`endif
        end
    end

    always_comb begin
        en        = 1'b0;
        serial_in = 1'b0;
        case (state)
            SHIFT: begin
                en        = 1'b1;
                serial_in = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            end
`ifdef SHIFT_FEEDER_PARITY_EN
            PARITY: begin
                en        = 1'b1;
                serial_in = parity;
            end
`endif
            default: begin
                en        = 1'b0;
                serial_in = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/serial_shift_feeder.md
Name: serial_shift_feeder

Overview:
- Upstream stage for the team's 8-bit serial-in shift register.
- Accepts parallel words over a valid/ready handshake into a one-entry holding buffer.
- Serialises each word onto serial_in, holding en high for exactly one cycle per bit. Inserts a programmable idle gap between frames.
- The holding buffer lets the next word be accepted while the current frame is shifting, so frames can run back-to-back.

Parameters:
- WIDTH, 8, bits per frame; must be >= 2.
- GAP_CYCLES, 1, idle cycles (en=0) between frames; 0 allows back-to-back frames.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer is empty; a word is accepted on an edge where in_valid && in_ready.
- serial_in  output  1  serial bit to the downstream shift register.
- en  output  1  shift enable to downstream; high only on bit cycles.
- busy  output  1  FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse in the cycle after a frame's last bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, hold_full=0, shift register=0, bit counter=0, gap counter=0.
  - Outputs: in_ready=1, en=0, serial_in=0, busy=0, frame_done=0.
  - Reset mid-frame aborts the frame immediately; en drops with no clock edge. The held word is discarded.
- Output timing: en, serial_in and busy are decoded only from registered state. There is no combinational path from in_valid/in_data to any output except in_ready, which is simply !hold_full.
- Buffer: on accept, hold_data <= in_data and hold_full <= 1. If the FSM loads from the buffer on the same edge as a new accept, hold_full stays 1 holding the new word.
- IDLE:
  - hold_full=1 -> next edge: load shreg from hold_data, bit_cnt <= 0, clear hold_full (unless a simultaneous accept), go to SHIFT.
  - Latency: accept at edge k -> hold_full at k -> load at edge k+1 -> first bit visible with en=1 after edge k+1.
- SHIFT:
  - en=1; serial_in = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - Each edge shifts shreg one place toward the output end, filling with 0, and increments bit_cnt.
  - On the edge ending bit WIDTH-1:
    - PARITY_EN defined -> go to PARITY.
    - Else if GAP_CYCLES>0 -> go to GAP with gap_cnt <= 0.
    - Else if hold_full -> reload and stay in SHIFT (back-to-back, no idle cycle).
    - Else -> go to IDLE.
- GAP:
  - en=0, serial_in=0.
  - After GAP_CYCLES cycles: hold_full -> load and go to SHIFT; else -> go to IDLE.
- frame_done: registered; high for exactly one cycle after the last bit (or the parity bit) of each frame, including back-to-back frames.
- Counters: bit_cnt is $clog2(WIDTH+1) bits wide; gap_cnt is $clog2(GAP_CYCLES+1) bits wide, minimum 1. Neither counter may overflow.
- in_valid held high with hold_full=1: ignored with no side effects; in_data may change freely.

Optional Feature:
- Macro: SHIFT_FEEDER_PARITY_EN.
- Defined: after the WIDTH data bits, one PARITY state drives en=1 and serial_in = even parity (XOR) of the frame's original word. Frame length is WIDTH+1 bits. GAP/IDLE/reload rules then apply from PARITY.
- Undefined: the PARITY state and the parity register are not synthesised. Frame length is WIDTH bits.

Decomposition:
- Package serial_pkg:
  - state enum typedef {IDLE, SHIFT, PARITY, GAP} (2-bit).
  - Localparam DEFAULT_FRAME_WIDTH = 8, shared with the downstream shift register's Q width.
- Sub-module hold_buffer: the one-entry valid/ready holding register (data, full flag, accept/pop). The FSM, shifter and counters stay in the top module.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release with in_valid=0 -> in_ready=1, en=0, busy=0, serial_in=0 for 10 cycles.
- Single frame (WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1): send 0xA5 -> en high for exactly 8 consecutive cycles starting 2 edges after the accept. serial_in = 1,0,1,0,0,1,0,1. frame_done pulses once. busy falls after the 1 gap cycle.
- Back-to-back (GAP_CYCLES=0): send 0x0F, then 0xF0 while the first is shifting -> 16 consecutive en cycles, serial_in = 00001111 11110000, two frame_done pulses. in_ready is low from the second accept until the second frame loads.
- LSB-first (MSB_FIRST=0): send 0x01 -> serial_in = 1,0,0,0,0,0,0,0.
- Reset mid-frame: assert reset=0 during bit 3 of 0xFF with 0x55 held -> en=0 immediately, hold discarded. After release: in_ready=1, busy=0, no further en pulses.
- Parity (SHIFT_FEEDER_PARITY_EN defined): send 0x07 -> 9 en cycles; 9th bit = 1. Send 0x03 -> 9th bit = 0.
